// File: rtl/delay_stream_feeder.sv
// Ping-pong staged frame source for the per-turbine delay line: the solver fills
// one bank while the other is streamed as N back-to-back words under sta.
module delay_stream_feeder #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int IDXW  = 4,
    parameter int DECIM = 1
) (
    input  logic            clk,
    input  logic            rst_user,
    input  logic            step_tick,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [W-1:0]    wr_data,
    input  logic            clr_overrun,
    output logic            sta,
    output logic [W-1:0]    x,
    output logic [IDXW-1:0] idx,
    output logic            frame_done,
    output logic            busy,
    output logic            overrun
);

    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int IW1   = IDXW + 1;

    localparam logic [IW1-1:0]  NLIM  = IW1'(N);
    localparam logic [IDXW-1:0] LAST  = IDXW'(N - 1);
    localparam logic [11:0]     DLAST = 12'(DECIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [11:0]     dcnt_q, dcnt_d;
    logic            overrun_q, overrun_d;
    logic [W-1:0]    x_q, x_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [W-1:0]    mem [2][DEPTH];

    logic            wr_ok;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [IDXW-1:0] idx_nxt;

    // Out-of-range indices are dropped here so the truncated address never aliases.
    assign wr_ok   = wr_en && ({1'b0, wr_idx} < NLIM);
    assign waddr   = wr_idx[AW-1:0];
    assign idx_nxt = idx_q + 1'b1;
    assign raddr   = (state_q == S_PRIME) ? '0 : idx_nxt[AW-1:0];

    // Staging RAM: solver always writes the bank that is not being streamed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[~rd_bank_q][waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            state_q   <= S_IDLE;
            rd_bank_q <= 1'b0;
            dcnt_q    <= '0;
            overrun_q <= 1'b0;
            x_q       <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            dcnt_q    <= dcnt_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        dcnt_d    = dcnt_q;
        x_d       = x_q;
        idx_d     = idx_q;
        overrun_d = overrun_q & ~clr_overrun;

        case (state_q)
            S_IDLE: begin
                if (step_tick) begin
                    if (dcnt_q == DLAST) begin
                        dcnt_d    = '0;
                        rd_bank_d = ~rd_bank_q;
                        state_d   = S_PRIME;
                    end else begin
                        dcnt_d = dcnt_q + 12'd1;
                    end
                end
            end
            S_PRIME: begin
                x_d     = mem[rd_bank_q][raddr];
                idx_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // x/idx hold the word on the bus; fetch runs one word ahead.
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    x_d   = mem[rd_bank_q][raddr];
                    idx_d = idx_nxt;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A dropped tick wins over a same-cycle clear.
        if (step_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign sta        = (state_q == S_STREAM);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign x          = x_q;
    assign idx        = idx_q;

endmodule

// File: tb/tb_delay_stream_feeder.sv
// Directed bench for delay_stream_feeder: a DECIM=1 and a DECIM=3 instance share
// stimulus; streamed words are checked against scoreboard queues.
module tb_delay_stream_feeder;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            rst_user = 1'b1;
    logic            step_tick = 1'b0;
    logic            wr_en = 1'b0;
    logic [IDXW-1:0] wr_idx = '0;
    logic [W-1:0]    wr_data = '0;
    logic            clr_overrun = 1'b0;

    logic            sta, frame_done, busy, overrun;
    logic [W-1:0]    x;
    logic [IDXW-1:0] idx;
    logic            sta3, fd3o, busy3, ov3;
    logic [W-1:0]    x3;
    logic [IDXW-1:0] idx3;

    int tests = 0, fails = 0;
    int fd1 = 0, fd3 = 0, nfr = 0, n3 = 0, fdb = 0;
    logic [35:0] sb[$];
    logic [35:0] sb3[$];
    logic [W-1:0] mdl [2][N];
    bit mrb = 1'b0;

    always #5 clk = ~clk;

    delay_stream_feeder #(.N(N), .W(W), .IDXW(IDXW), .DECIM(1)) dut (
        .clk(clk), .rst_user(rst_user), .step_tick(step_tick), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_data(wr_data), .clr_overrun(clr_overrun),
        .sta(sta), .x(x), .idx(idx), .frame_done(frame_done), .busy(busy),
        .overrun(overrun)
    );

    delay_stream_feeder #(.N(N), .W(W), .IDXW(IDXW), .DECIM(3)) dut3 (
        .clk(clk), .rst_user(rst_user), .step_tick(step_tick), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_data(wr_data), .clr_overrun(clr_overrun),
        .sta(sta3), .x(x3), .idx(idx3), .frame_done(fd3o), .busy(busy3),
        .overrun(ov3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [35:0] e;
        if (sta) begin
            chk("sb_avail", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("x", 64'(x), 64'(e[31:0]));
                chk("idx", 64'(idx), 64'(e[35:32]));
            end
        end
        if (sta3) begin
            chk("sb3_avail", 64'(sb3.size() > 0), 64'd1);
            if (sb3.size() > 0) begin
                e = sb3.pop_front();
                chk("x3", 64'(x3), 64'(e[31:0]));
                chk("idx3", 64'(idx3), 64'(e[35:32]));
            end
        end
        if (frame_done) fd1++;
        if (fd3o) fd3++;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    task automatic wr(input logic [IDXW-1:0] i, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_idx  = i;
        wr_data = d;
        if (i < N) mdl[!mrb][i[1:0]] = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rst_pulse();
        rst_user = 1'b1;
        cyc();
        rst_user = 1'b0;
        cyc();
        mrb = 1'b0;
        sb.delete();
        sb3.delete();
    endtask

    // Launch a frame with a tick in the current cycle, check its timing, and
    // optionally refill the other bank while it streams.
    task automatic frame(input bit do_wr, input logic [W-1:0] base, input logic [W-1:0] stp,
                         input int drop_at, input bit clr_drop, input bit d3);
        if (wr_en && wr_idx < N) mdl[!mrb][wr_idx[1:0]] = wr_data;
        mrb = !mrb;
        for (int j = 0; j < N; j++) begin
            sb.push_back({4'(j), mdl[mrb][j]});
            if (d3) sb3.push_back({4'(j), mdl[mrb][j]});
        end
        nfr++;
        if (d3) n3++;
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        wr_en     = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            chk("busy", 64'(busy), 64'(r <= 6));
            chk("sta", 64'(sta), 64'(r >= 2 && r <= 5));
            chk("frame_done", 64'(frame_done), 64'(r == 6));
            step_tick   = (r == drop_at);
            clr_overrun = (r == drop_at) && clr_drop;
            if (do_wr && r <= N) begin
                wr_en   = 1'b1;
                wr_idx  = IDXW'(r - 1);
                wr_data = base + stp * 32'(r - 1);
                mdl[!mrb][r-1] = wr_data;
            end else begin
                wr_en = 1'b0;
            end
            cyc();
        end
        repeat (2) cyc();
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_sta", 64'(sta), 64'd0);
        chk("rst_x", 64'(x), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_fdone", 64'(frame_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst_user = 1'b0;
        repeat (2) cyc();

        // Basic frame, refilling the other bank mid-frame (ping-pong isolation)
        wr(4'd0, 32'h3F80_0000);
        wr(4'd1, 32'h4000_0000);
        wr(4'd2, 32'h4040_0000);
        wr(4'd3, 32'h4080_0000);
        frame(1'b1, 32'h1111_1111, 32'h1111_1111, 0, 1'b0, 1'b0);
        frame(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        chk("overrun_idle", 64'(overrun), 64'd0);

        // Decimation by 3; the 6th tick also carries a dropped tick
        rst_pulse();
        for (int j = 0; j < N; j++) wr(IDXW'(j), 32'h2000_0000 + 32'(j));
        for (int t = 1; t <= 9; t++) begin
            frame(1'b1, 32'h2000_0000 + 32'(t) * 32'h100, 32'd1, (t == 6) ? 3 : 0, 1'b0, (t % 3) == 0);
            chk("fd3_count", 64'(fd3), 64'(t / 3));
            chk("overrun_drop", 64'(overrun), 64'(t >= 6));
            if (t == 6) chk("overrun3_drop", 64'(ov3), 64'd1);
        end

        // Clear, then a dropped tick coinciding with a clear
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        chk("overrun_clr", 64'(overrun), 64'd0);
        chk("overrun3_clr", 64'(ov3), 64'd0);
        frame(1'b1, 32'h3000_0000, 32'd1, 3, 1'b1, 1'b0);
        chk("overrun_drop_clr", 64'(overrun), 64'd1);

        // Reset during the second streamed word
        rst_pulse();
        for (int j = 0; j < N; j++) wr(IDXW'(j), 32'h5000_0000 + 32'(j));
        mrb = !mrb;
        for (int j = 0; j < N; j++) sb.push_back({4'(j), mdl[mrb][j]});
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc();
        @(posedge clk);
        #2 rst_user = 1'b1;
        #1;
        chk("midrst_sta", 64'(sta), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_x", 64'(x), 64'd0);
        chk("midrst_idx", 64'(idx), 64'd0);
        sb.delete();
        mrb = 1'b0;
        @(negedge clk);
        rst_user = 1'b0;
        fdb = fd1;
        repeat (8) cyc();
        chk("midrst_no_fdone", 64'(fd1), 64'(fdb));
        for (int j = 0; j < N; j++) wr(IDXW'(j), 32'h6000_0000 + 32'(j));
        frame(1'b1, 32'h7000_0000, 32'd1, 0, 1'b0, 1'b0);

        // Out-of-range writes, then a write landing in the tick cycle
        wr(4'd4, 32'hDEAD_BEEF);
        wr(4'd5, 32'hDEAD_BEEF);
        wr(4'd15, 32'hDEAD_BEEF);
        frame(1'b1, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b0);
        wr_en   = 1'b1;
        wr_idx  = 4'd0;
        wr_data = 32'hCAFE_F00D;
        frame(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1);

        repeat (4) cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sb3_drained", 64'(sb3.size()), 64'd0);
        chk("frames", 64'(fd1), 64'(nfr));
        chk("frames3", 64'(fd3), 64'(n3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/delay_stream_feeder.md
# delay_stream_feeder

Time-multiplexed frame source that feeds the per-turbine delay line. The upstream wind-turbine solver writes one value per turbine into a ping-pong staging buffer at any time within a simulation step. On each accepted step tick, the block swaps banks and streams the frozen bank out as N back-to-back words with `sta` held high, in the format the delay line consumes. An optional decimation factor lets the delay path run at a sub-multiple of the solver step rate.

## Interface
- N, 4 (`N_WindTurbine`): turbines per frame; 1..2^IDXW
- W, 32 (`SINGLE`): data word width
- IDXW, 4: turbine index width
- DECIM, 1: frames issued once per DECIM accepted step ticks; 1..4095
- clk  in  1  clock
- rst_user  in  1  reset, asynchronous, active-high
- step_tick  in  1  one-cycle pulse, start of solver step
- wr_en  in  1  staging write strobe
- wr_idx  in  IDXW  turbine index of write
- wr_data  in  W  value to stage
- clr_overrun  in  1  synchronous clear of overrun
- sta  out  1  high for exactly N consecutive cycles per frame
- x  out  W  streamed word, valid while sta=1
- idx  out  IDXW  turbine index of x, valid while sta=1
- frame_done  out  1  one-cycle pulse after last word
- busy  out  1  frame in progress, ticks not accepted
- overrun  out  1  sticky: tick arrived while busy

## Operation
- Storage: two banks of N×W words, 1-cycle registered read. rd_bank selects the streaming bank; writes always go to bank ~rd_bank.
- Writes: wr_en=1 with wr_idx<N writes wr_data to the write bank at that edge. wr_idx≥N is ignored with no side effects. Writes are accepted in every state.
- Decimation counter dcnt (12 bit): each step_tick sampled in IDLE increments dcnt. When dcnt==DECIM-1, dcnt resets to 0 and a frame starts. With DECIM=1, every idle tick starts a frame.
- FSM states:
  - IDLE: on frame start, toggle rd_bank and go to PRIME.
  - PRIME: present read address 0; go to STREAM.
  - STREAM: counter k counts 0..N-1; sta=1, x=bank[rd_bank][k], idx=k. Read address runs one ahead. After k=N-1, go to DONE.
  - DONE: frame_done=1; go to IDLE.
- busy=1 in PRIME, STREAM and DONE.
- A step_tick when busy=1 is dropped. It sets overrun=1 and does not advance dcnt.
- clr_overrun clears overrun. If a dropped tick and clr_overrun occur in the same cycle, overrun stays set.
- A write in the same cycle as the frame-starting tick lands in the bank about to stream and appears in that frame. The first read occurs two edges later, so there is no hazard.
- Writes during a frame go to the other bank and never alter the frame in flight.
- x and idx hold their last values when sta=0 (don't-care for consumers).

## Timing
- Reset values: sta=0, x=0, idx=0, frame_done=0, busy=0, overrun=0. Internal state: rd_bank=0, dcnt=0, FSM=IDLE. Staging RAM contents are undefined after reset.
- Asserting rst_user mid-frame drops all outputs to reset values immediately. The frame is aborted and no frame_done is produced.
- If step_tick is accepted at edge t (cycle t):
  - busy is high in cycles t+1..t+N+2.
  - sta is high in cycles t+2..t+N+1.
  - frame_done fires in cycle t+N+2.
- The earliest next accepted tick is in cycle t+N+3, so the minimum tick period is N+3 cycles.
- Latency from write to output: a write completed by edge t (the tick edge) is visible in the frame launched by that tick.

## Test plan
- Basic frame (N=4, DECIM=1): after reset, write 0x3F800000, 0x40000000, 0x40400000, 0x40800000 to idx 0..3, then tick at cycle 10 → sta=1 in cycles 12..15, x in that order, idx 0,1,2,3, frame_done=1 in cycle 16, busy=1 in cycles 11..16.
- Ping-pong isolation: during frame 1, write 0x11111111..0x44444444 to idx 0..3 → frame 1 is unchanged. A tick at cycle ≥17 streams 0x11111111..0x44444444.
- Decimation (DECIM=3): 6 ticks spaced 10 cycles apart → exactly 2 frames, launched by the 3rd and 6th ticks.
- Overrun: tick while busy → overrun=1, no extra frame, dcnt unchanged. Pulse clr_overrun → overrun=0 the next cycle. A simultaneous dropped tick and clr_overrun leaves overrun=1.
- Reset mid-stream: assert rst_user during the 2nd sta cycle → sta, busy, x and idx are 0 in the same cycle and no frame_done follows. After release, write and tick → a normal frame, streamed from bank 1.
- Index guard and same-cycle write: wr_idx=4 with N=4 → no word changes. A write to idx 0 in the tick cycle → appears as the first x of that frame.
